sad_search_ctrl: RTL and testbench
==================================

// Module: sad_search_ctrl
// PURPOSE
//  Sequences one compute_sad datapath instance (instantiated inside) over a block of BLK_ROWS rows.
//  Keeps the 3-row current-pixel sliding window and paces the current-row and original-row streams.
//  Accumulates the 25 sub-pel candidate SADs (5 vertical x 5 horizontal) over the block.
//  Then scans the 25 sums and returns the best candidate position and its SAD.
//  Sits between the frame fetch logic and the motion-vector decision stage of the ME pipeline.
// PARAMETERS
//  BLK_ROWS  8   org rows per block; the block consumes BLK_ROWS+2 cur rows
//  ACC_W     15  accumulator width; must be >= 12+clog2(BLK_ROWS); no saturation is needed
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous active-high reset
//  start      in   1      1-cycle pulse: begin a block; honoured only in IDLE
//  busy       out  1      high in every state except IDLE
//  cur_row    in   64     8 cur pixels; pixel i at [8i+7:8i]
//  cur_valid  in   1      cur_row valid
//  cur_ready  out  1      cur_row accepted when cur_valid&&cur_ready
//  org_row    in   48     6 org pixels; pixel i at [8i+7:8i]
//  org_valid  in   1      org_row valid
//  org_ready  out  1      org_row accepted when org_valid&&org_ready
//  out_sad    out  ACC_W  best accumulated SAD
//  out_vpos   out  3      best vertical pos: 0=UH 1=UQ 2=M 3=LQ 4=LH
//  out_hpos   out  3      best horizontal pos: lane k=0..4 of the 60-bit SAD bus ([12k+11:12k])
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      result consumer ready
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 (busy, cur_ready, org_ready, out_*). Window and accumulators cleared.
//  Reset mid-operation aborts the block; state is IDLE on the next cycle.
//  FSM: IDLE -> PRIME -> RUN -> SCAN -> DONE -> IDLE.
//  IDLE: start=1 clears all 25 accumulators and moves to PRIME. start is ignored in every other state.
//  PRIME: cur_ready=1, org_ready=0.
//   - Each accepted cur row shifts in: upper<=middle; middle<=cur_row.
//   - After 2 accepted rows -> RUN.
//  RUN: cur_ready = org_valid; org_ready = cur_valid. A step occurs only when both are valid.
//   - compute_sad is fed combinationally: upper=upper reg, middle=middle reg, lower=cur_row, org=org_row.
//   - On a step, acc[v][h] += zero-extended 12-bit SAD lane. Window shifts: upper<=middle; middle<=cur_row.
//   - Row counter increments on each step. After BLK_ROWS steps -> SCAN.
//   - No accumulator or window change on a cycle without a step.
//  SCAN: best is preloaded with the centre candidate (v=2,h=2).
//   - Takes 25 cycles, idx 0..24 (v=idx/5, h=idx%5).
//   - Replace best only if acc[idx] < best (strict): ties keep the centre, otherwise the lowest idx.
//   - Then -> DONE.
//  DONE: out_valid=1; out_sad/out_vpos/out_hpos are stable while out_valid=1.
//   - On out_valid&&out_ready: out_valid drops next cycle and state -> IDLE.
//  Full-rate latency: start to out_valid = 1+2+BLK_ROWS+25 cycles (36 at default).
//  cur_ready/org_ready are 0 in IDLE, SCAN and DONE. Extra input beats wait; they are not dropped.
// TESTING
//  1. cur all 0x10, org all 0x10 -> every acc=0; out vpos=2 hpos=2 sad=0 (centre tie-break).
//  2. cur all 0x01, org all 0x00 -> every acc=6*8=48; out (2,2) sad=48; out_valid 36 cycles after start.
//  3. cur all 0xFF, org all 0x00 -> sad=12240, no overflow in 15 bits.
//  4. Golden-model pattern with a unique minimum at v=0 h=4 -> out (0,4) and the golden SAD.
//     Repeat with random cur/org valid gaps -> identical result; acc unchanged on non-step cycles.
//  5. out_ready low 10 cycles in DONE, start pulsed meanwhile -> out fields held, start ignored, busy=1;
//     release -> IDLE.
//  6. rst after 3 RUN steps -> next cycle IDLE, all outputs 0; a fresh block then reproduces test 2 exactly.

Source files
------------

// File: rtl/sad_search_ctrl.sv
// ============================================================================
//  Module      : sad_search_ctrl (with compute_sad datapath)
//  Description : Sub-pel SAD search over one block. Accumulates 25 candidate
//                SADs and reports the best candidate position and its SAD.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

// Interpolates a 3-row cur window to 5x5 sub-pel positions and produces one
// 12-bit SAD per candidate against 6 org pixels (org j aligned to cur j+1).
module compute_sad (
  input  logic [63:0]  upper,
  input  logic [63:0]  middle,
  input  logic [63:0]  lower,
  input  logic [47:0]  org,
  output logic [299:0] sad
);

  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  // (3*near + far + 2) >> 2
  function automatic logic [7:0] avg4(input logic [7:0] near, input logic [7:0] far);
    logic [9:0] s;
    s = {2'b0, near} + {1'b0, near, 1'b0} + {2'b0, far} + 10'd2;
    return s[9:2];
  endfunction

  function automatic logic [7:0] hinterp(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] n, input logic [2:0] h);
    case (h)
      3'd0:    return avg2(a, b);
      3'd1:    return avg4(b, a);
      3'd2:    return b;
      3'd3:    return avg4(b, n);
      default: return avg2(b, n);
    endcase
  endfunction

  logic [7:0]  vcol [5][8];
  logic [11:0] lane;
  logic [7:0]  p, o, d;

  always_comb begin
    for (int c = 0; c < 8; c++) begin
      vcol[0][c] = avg2(upper[8*c +: 8], middle[8*c +: 8]);
      vcol[1][c] = avg4(middle[8*c +: 8], upper[8*c +: 8]);
      vcol[2][c] = middle[8*c +: 8];
      vcol[3][c] = avg4(middle[8*c +: 8], lower[8*c +: 8]);
      vcol[4][c] = avg2(middle[8*c +: 8], lower[8*c +: 8]);
    end
  end

  always_comb begin
    sad  = '0;
    lane = '0;
    p    = '0;
    o    = '0;
    d    = '0;
    for (int v = 0; v < 5; v++) begin
      for (int h = 0; h < 5; h++) begin
        lane = '0;
        for (int j = 0; j < 6; j++) begin
          p    = hinterp(vcol[v][j], vcol[v][j+1], vcol[v][j+2], 3'(h));
          o    = org[8*j +: 8];
          d    = (p > o) ? p - o : o - p;
          lane = lane + {4'b0, d};
        end
        sad[60*v + 12*h +: 12] = lane;
      end
    end
  end

endmodule

module sad_search_ctrl #(
  parameter int BLK_ROWS = 8,
  parameter int ACC_W    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  input  logic [63:0]      cur_row,
  input  logic             cur_valid,
  output logic             cur_ready,
  input  logic [47:0]      org_row,
  input  logic             org_valid,
  output logic             org_ready,
  output logic [ACC_W-1:0] out_sad,
  output logic [2:0]       out_vpos,
  output logic [2:0]       out_hpos,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(BLK_ROWS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [63:0]                     upper_q, upper_d;
  logic [63:0]                     middle_q, middle_d;
  logic [4:0][4:0][ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]                row_cnt_q, row_cnt_d;
  logic [2:0]                      scan_v_q, scan_v_d;
  logic [2:0]                      scan_h_q, scan_h_d;
  logic [ACC_W-1:0]                best_sad_q, best_sad_d;
  logic [2:0]                      best_v_q, best_v_d;
  logic [2:0]                      best_h_q, best_h_d;
  logic                            out_valid_q, out_valid_d;
  logic                            busy_q, busy_d;
  logic                            step;
  logic [299:0]                    sad_bus;

  compute_sad u_compute_sad (
    .upper  (upper_q),
    .middle (middle_q),
    .lower  (cur_row),
    .org    (org_row),
    .sad    (sad_bus)
  );

  always_comb begin
    state_d     = state_q;
    upper_d     = upper_q;
    middle_d    = middle_q;
    acc_d       = acc_q;
    row_cnt_d   = row_cnt_q;
    scan_v_d    = scan_v_q;
    scan_h_d    = scan_h_q;
    best_sad_d  = best_sad_q;
    best_v_d    = best_v_q;
    best_h_d    = best_h_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    cur_ready   = 1'b0;
    org_ready   = 1'b0;
    step        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d     = '0;
          row_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = S_PRIME;
        end
      end

      S_PRIME: begin
        cur_ready = 1'b1;
        if (cur_valid) begin
          upper_d   = middle_q;
          middle_d  = cur_row;
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == CNT_W'(1)) begin
            row_cnt_d = '0;
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        // Each stream is only taken together with the other one.
        cur_ready = org_valid;
        org_ready = cur_valid;
        step      = cur_valid && org_valid;
        if (step) begin
          for (int v = 0; v < 5; v++)
            for (int h = 0; h < 5; h++)
              acc_d[v][h] = acc_q[v][h] + ACC_W'(sad_bus[60*v + 12*h +: 12]);
          upper_d   = middle_q;
          middle_d  = cur_row;
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == CNT_W'(BLK_ROWS - 1)) begin
            state_d    = S_SCAN;
            scan_v_d   = '0;
            scan_h_d   = '0;
            best_sad_d = acc_d[2][2];
            best_v_d   = 3'd2;
            best_h_d   = 3'd2;
          end
        end
      end

      S_SCAN: begin
        if (acc_q[scan_v_q][scan_h_q] < best_sad_q) begin
          best_sad_d = acc_q[scan_v_q][scan_h_q];
          best_v_d   = scan_v_q;
          best_h_d   = scan_h_q;
        end
        if (scan_h_q == 3'd4) begin
          scan_h_d = '0;
          scan_v_d = scan_v_q + 3'd1;
        end else begin
          scan_h_d = scan_h_q + 3'd1;
        end
        if (scan_v_q == 3'd4 && scan_h_q == 3'd4) begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      upper_q     <= '0;
      middle_q    <= '0;
      acc_q       <= '0;
      row_cnt_q   <= '0;
      scan_v_q    <= '0;
      scan_h_q    <= '0;
      best_sad_q  <= '0;
      best_v_q    <= '0;
      best_h_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      upper_q     <= upper_d;
      middle_q    <= middle_d;
      acc_q       <= acc_d;
      row_cnt_q   <= row_cnt_d;
      scan_v_q    <= scan_v_d;
      scan_h_q    <= scan_h_d;
      best_sad_q  <= best_sad_d;
      best_v_q    <= best_v_d;
      best_h_q    <= best_h_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_sad   = best_sad_q;
  assign out_vpos  = best_v_q;
  assign out_hpos  = best_h_q;

endmodule

`default_nettype wire

// File: tb/tb_sad_search_ctrl.sv
// ============================================================================
//  Module      : tb_sad_search_ctrl
//  Description : Directed self-checking bench for sad_search_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sad_search_ctrl;

  localparam int BLK = 8;

  logic        clk = 1'b0;
  logic        rst, start, busy;
  logic [63:0] cur_row;
  logic        cur_valid, cur_ready;
  logic [47:0] org_row;
  logic        org_valid, org_ready;
  logic [14:0] out_sad;
  logic [2:0]  out_vpos, out_hpos;
  logic        out_valid, out_ready;

  logic [63:0] cur_rows [BLK+2];
  logic [47:0] org_rows [BLK];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sad_search_ctrl #(.BLK_ROWS(BLK), .ACC_W(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .cur_row   (cur_row),
    .cur_valid (cur_valid),
    .cur_ready (cur_ready),
    .org_row   (org_row),
    .org_valid (org_valid),
    .org_ready (org_ready),
    .out_sad   (out_sad),
    .out_vpos  (out_vpos),
    .out_hpos  (out_hpos),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] cv, input logic [7:0] ov);
    for (int r = 0; r < BLK+2; r++) cur_rows[r] = {8{cv}};
    for (int s = 0; s < BLK; s++)   org_rows[s] = {6{ov}};
  endtask

  // Linear ramp: org matches the upper-half / right-half candidate exactly.
  task automatic fill_grad();
    for (int r = 0; r < BLK+2; r++)
      for (int i = 0; i < 8; i++) cur_rows[r][8*i +: 8] = 8'(8*i + 20*r);
    for (int s = 0; s < BLK; s++)
      for (int j = 0; j < 6; j++) org_rows[s][8*j +: 8] = 8'(8*j + 20*s + 22);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < BLK+2; r++)
      for (int i = 0; i < 8; i++) cur_rows[r][8*i +: 8] = 8'($urandom_range(0, 255));
    for (int s = 0; s < BLK; s++)
      for (int j = 0; j < 6; j++) org_rows[s][8*j +: 8] = 8'($urandom_range(0, 255));
  endtask

  function automatic int pc(int r, int i);
    return int'(cur_rows[r][8*i +: 8]);
  endfunction

  function automatic int vint(int s, int v, int c);
    int u, m, l;
    u = pc(s, c); m = pc(s+1, c); l = pc(s+2, c);
    if (v == 0) return (u + m + 1) / 2;
    if (v == 1) return (u + 3*m + 2) / 4;
    if (v == 2) return m;
    if (v == 3) return (3*m + l + 2) / 4;
    return (m + l + 1) / 2;
  endfunction

  function automatic int hint(int s, int v, int h, int j);
    int x, y, z;
    x = vint(s, v, j); y = vint(s, v, j+1); z = vint(s, v, j+2);
    if (h == 0) return (x + y + 1) / 2;
    if (h == 1) return (x + 3*y + 2) / 4;
    if (h == 2) return y;
    if (h == 3) return (3*y + z + 2) / 4;
    return (y + z + 1) / 2;
  endfunction

  task automatic golden(output int bs, output int bv, output int bh);
    int a [25];
    int d;
    for (int idx = 0; idx < 25; idx++) begin
      a[idx] = 0;
      for (int s = 0; s < BLK; s++)
        for (int j = 0; j < 6; j++) begin
          d = hint(s, idx/5, idx%5, j) - int'(org_rows[s][8*j +: 8]);
          a[idx] += (d < 0) ? -d : d;
        end
    end
    bs = a[12]; bv = 2; bh = 2;
    for (int idx = 0; idx < 25; idx++)
      if (a[idx] < bs) begin bs = a[idx]; bv = idx / 5; bh = idx % 5; end
  endtask

  // Pulses start and streams the stored rows until out_valid, or until
  // stop_org org rows have been accepted (stop_org >= 0).
  task automatic feed(input bit gaps, input int stop_org, output int lat, output bit ok);
    int ci, oi, cyc;
    bit take_c, take_o;
    ci = 0; oi = 0; cyc = 0; lat = -1; ok = 1'b0;
    while (cyc < 600 && !ok) begin
      @(negedge clk);
      start     = (cyc == 0);
      cur_valid = (ci < BLK+2) && (!gaps || $urandom_range(0, 2) != 0);
      org_valid = (oi < BLK) && (!gaps || $urandom_range(0, 2) != 0);
      cur_row   = (ci < BLK+2) ? cur_rows[ci] : 64'd0;
      org_row   = (oi < BLK) ? org_rows[oi] : 48'd0;
      #1;
      take_c = cur_valid && cur_ready;
      take_o = org_valid && org_ready;
      @(posedge clk);
      cyc++;
      if (take_c) ci++;
      if (take_o) oi++;
      #1;
      if (out_valid) begin
        lat = cyc;
        ok  = 1'b1;
      end else if (stop_org >= 0 && oi == stop_org) begin
        ok = 1'b1;
      end
    end
    start = 1'b0; cur_valid = 1'b0; org_valid = 1'b0;
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_valid_drop"}, out_valid, 0);
    check_val({tag, "_busy_drop"}, busy, 0);
  endtask

  task automatic run_block(input string tag, input bit gaps, input int es, input int ev,
                           input int eh, input int elat);
    int  lat;
    bit  ok;
    feed(gaps, -1, lat, ok);
    check_val({tag, "_done"}, ok, 1);
    if (elat >= 0) check_val({tag, "_latency"}, lat, elat);
    check_val({tag, "_sad"}, out_sad, es);
    check_val({tag, "_vpos"}, out_vpos, ev);
    check_val({tag, "_hpos"}, out_hpos, eh);
    check_val({tag, "_busy"}, busy, 1);
    release_result(tag);
  endtask

  initial begin
    int  gs, gv, gh, lat;
    bit  ok;

    rst = 1'b1; start = 1'b0; cur_row = '0; cur_valid = 1'b0;
    org_row = '0; org_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_cur_ready", cur_ready, 0);
    check_val("rst_org_ready", org_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_sad", out_sad, 0);
    check_val("rst_out_vpos", out_vpos, 0);
    check_val("rst_out_hpos", out_hpos, 0);
    @(negedge clk);
    rst = 1'b0;

    fill_const(8'h10, 8'h10);
    run_block("equal", 1'b0, 0, 2, 2, 36);

    fill_const(8'h01, 8'h00);
    run_block("ones", 1'b0, 48, 2, 2, 36);

    fill_const(8'hFF, 8'h00);
    run_block("max", 1'b0, 12240, 2, 2, 36);

    fill_grad();
    run_block("grad", 1'b0, 0, 0, 4, 36);
    run_block("grad_gaps", 1'b1, 0, 0, 4, -1);

    fill_rand();
    golden(gs, gv, gh);
    run_block("rand", 1'b0, gs, gv, gh, 36);
    run_block("rand_gaps", 1'b1, gs, gv, gh, -1);

    // Result held with out_ready low; start and input beats must be ignored.
    fill_const(8'h01, 8'h00);
    feed(1'b0, -1, lat, ok);
    check_val("hold_done", ok, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start     = (k == 3);
      cur_valid = 1'b1;
      org_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    check_val("hold_cur_ready", cur_ready, 0);
    check_val("hold_org_ready", org_ready, 0);
    start = 1'b0; cur_valid = 1'b0; org_valid = 1'b0;
    check_val("hold_valid", out_valid, 1);
    check_val("hold_busy", busy, 1);
    check_val("hold_sad", out_sad, 48);
    check_val("hold_vpos", out_vpos, 2);
    check_val("hold_hpos", out_hpos, 2);
    release_result("hold");

    // Abort after 3 RUN steps, then a fresh block must match the ones case.
    feed(1'b0, 3, lat, ok);
    check_val("abort_reached", ok, 1);
    check_val("abort_busy_pre", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_cur_ready", cur_ready, 0);
    check_val("abort_org_ready", org_ready, 0);
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_out_sad", out_sad, 0);
    check_val("abort_out_vpos", out_vpos, 0);
    check_val("abort_out_hpos", out_hpos, 0);
    @(negedge clk);
    rst = 1'b0;
    run_block("after_abort", 1'b0, 48, 2, 2, 36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
